// File: rtl/lab1_imul_pkg.sv
// Shared types and mux-select encodings for the variable-latency iterative multiplier.
package lab1_imul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic A_LD    = 1'b0;
  localparam logic A_SHF   = 1'b1;
  localparam logic B_LD    = 1'b0;
  localparam logic B_SHF   = 1'b1;
  localparam logic RES_CLR = 1'b0;
  localparam logic RES_ADD = 1'b1;

endpackage

// File: rtl/lab1_imul_var_lat_ctrl.sv
// Control FSM for the variable-latency iterative multiplier (IDLE/CALC/DONE).
// Define LAB1_IMUL_ZERO_SKIP_EN to shift by the datapath's trailing-zero amount instead of 1.
module lab1_imul_var_lat_ctrl
  import lab1_imul_pkg::*;
#(
  parameter  int unsigned NBITS   = 32,
  localparam int unsigned SHAMT_W = $clog2(NBITS),
  localparam int unsigned CNT_W   = $clog2(NBITS) + 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req_val,
  output logic               req_rdy,
  output logic               resp_val,
  input  logic               resp_rdy,
  input  logic               b_lsb,
  input  logic               b_hi_zero,
  input  logic [SHAMT_W-1:0] shift_in,
  output logic               a_mux_sel,
  output logic               b_mux_sel,
  output logic               result_mux_sel,
  output logic               a_en,
  output logic               b_en,
  output logic               result_en,
  output logic [SHAMT_W-1:0] shift_amt,
  output logic [CNT_W-1:0]   iter_cnt
);

  state_t             state;
  logic [SHAMT_W-1:0] shift_step;

`ifdef LAB1_IMUL_ZERO_SKIP_EN
  assign shift_step = shift_in;
`else
  logic unused_shift_in;
  assign shift_step      = SHAMT_W'(1);
  assign unused_shift_in = ^shift_in;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (req_val)   state <= CALC;
        CALC:    if (b_hi_zero) state <= DONE;
        DONE:    if (resp_rdy)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Trace counter: CALC cycles of the current transaction, saturating.
  always_ff @(posedge clk) begin
    if (reset) begin
      iter_cnt <= '0;
    end else begin
      case (state)
        IDLE: if (req_val) iter_cnt <= '0;
        CALC: if (iter_cnt != '1) iter_cnt <= iter_cnt + CNT_W'(1);
        default: ;
      endcase
    end
  end

  always_comb begin
    req_rdy        = 1'b0;
    resp_val       = 1'b0;
    a_mux_sel      = A_LD;
    b_mux_sel      = B_LD;
    result_mux_sel = RES_CLR;
    a_en           = 1'b0;
    b_en           = 1'b0;
    result_en      = 1'b0;
    shift_amt      = '0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_val) begin
          a_en      = 1'b1;
          b_en      = 1'b1;
          result_en = 1'b1;
        end
      end
      CALC: begin
        // The accumulate still happens on the exit cycle.
        result_en      = b_lsb;
        result_mux_sel = RES_ADD;
        if (!b_hi_zero) begin
          a_en      = 1'b1;
          b_en      = 1'b1;
          a_mux_sel = A_SHF;
          b_mux_sel = B_SHF;
          shift_amt = shift_step;
        end
      end
      DONE:    resp_val = 1'b1;
      default: ;
    endcase
  end

endmodule
